// File: rtl/present_dec_ctrl_if.sv
// Host-side handshake bundle for the PRESENT-80 decryption engine.
// start/ciphertext/key flow from host to engine; busy/done/plaintext flow back.
interface present_dec_ctrl_if;
    logic        start;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] plaintext;

    modport master (
        output start, ciphertext, key,
        input  busy, done, plaintext
    );

    modport slave (
        input  start, ciphertext, key,
        output busy, done, plaintext
    );
endinterface

// File: rtl/present_dec_ctrl.sv
// Purpose: iterative PRESENT-80 decryption, forward key walk then 31 inverse rounds.
// Latency: done pulses 63 cycles after the accepting edge; plaintext held until next done.
// Backpressure: none; start is only sampled in IDLE, so a new op is accepted every 64 cycles at best.
module present_dec_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic              Clock,
    input  logic              Reset_n,
    present_dec_ctrl_if.slave host
);

    typedef enum logic [1:0] {IDLE, KEYFWD, WHITEN, ROUND} fsm_t;

    localparam logic [4:0] RC_LAST = 5'(ROUNDS);

    fsm_t        fsm, fsm_nxt;
    logic [63:0] state;
    logic [79:0] k;
    logic [4:0]  rc;
    logic        busy_r, done_r;
    logic [63:0] plaintext_r;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sinv(input logic [3:0] x);
        case (x)
            4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
            4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
            4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
            4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
        endcase
    endfunction

    // Forward key step (K_rc -> K_rc+1) and its exact inverse (K_rc+1 -> K_rc).
    logic [79:0] k_rot, k_fwd, k_tmp, k_bwd;
    assign k_rot = {k[18:0], k[79:19]};
    assign k_fwd = {sbox(k_rot[79:76]), k_rot[75:20], k_rot[19:15] ^ rc, k_rot[14:0]};
    assign k_tmp = {sinv(k[79:76]), k[75:20], k[19:15] ^ rc, k[14:0]};
    assign k_bwd = {k_tmp[60:0], k_tmp[79:61]};

    // Inverse round datapath: inverse P-layer, inverse S-box, XOR with the unwound key.
    logic [63:0] p, s, rnd;
    for (genvar i = 0; i < 63; i++) begin : g_pinv
        assign p[i] = state[(16 * i) % 63];
    end
    assign p[63] = state[63];

    for (genvar n = 0; n < 16; n++) begin : g_sinv
        assign s[4*n +: 4] = sinv(p[4*n +: 4]);
    end
    assign rnd = s ^ k_bwd[79:16];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) fsm <= IDLE;
        else          fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (host.start)    fsm_nxt = KEYFWD;
            KEYFWD:  if (rc == RC_LAST) fsm_nxt = WHITEN;
            WHITEN:                     fsm_nxt = ROUND;
            ROUND:   if (rc == 5'd1)    fsm_nxt = IDLE;
            default:                    fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= '0;
            k           <= '0;
            rc          <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            plaintext_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (host.start) begin
                        state  <= host.ciphertext;
                        k      <= host.key;
                        rc     <= 5'd1;
                        busy_r <= 1'b1;
                    end
                end
                KEYFWD: begin
                    k  <= k_fwd;
                    rc <= (rc == RC_LAST) ? RC_LAST : rc + 5'd1;
                end
                WHITEN: state <= state ^ k[79:16];
                ROUND: begin
                    k     <= k_bwd;
                    state <= rnd;
                    rc    <= rc - 5'd1;
                    if (rc == 5'd1) begin
                        plaintext_r <= rnd;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign host.busy      = busy_r;
    assign host.done      = done_r;
    assign host.plaintext = plaintext_r;

endmodule

// File: tb/tb_present_dec_ctrl.sv
// Directed bench for present_dec_ctrl: known-answer table plus held-start and mid-op reset sequences.
module tb_present_dec_ctrl;

    logic Clock = 1'b0;
    logic Reset_n;
    always #5 Clock = ~Clock;

    present_dec_ctrl_if dif ();

    present_dec_ctrl #(.ROUNDS(31)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .host    (dif.slave)
    );

    typedef struct {
        logic [63:0] ct;
        logic [79:0] key;
        logic [63:0] pt;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no done within cycle budget", name);
    endtask

    task automatic scramble();
        dif.ciphertext = {$urandom, $urandom};
        dif.key        = {$urandom, $urandom, 16'($urandom)};
    endtask

    // Call away from the clock edge; start is pulsed for one cycle only.
    task automatic run_op(input vec_t v, input bit chk_k32);
        int  busy_cnt;
        int  lat;
        bit  got;
        dif.start      = 1'b1;
        dif.ciphertext = v.ct;
        dif.key        = v.key;
        @(posedge Clock); #1;
        dif.start = 1'b0;
        scramble();
        check("busy_after_accept", 80'(dif.busy), 80'(1));
        busy_cnt = 1;
        lat      = 0;
        got      = 1'b0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(posedge Clock); #1;
            if (chk_k32 && n == 32)
                check("k32_after_whiten", 80'(dut.k[79:16]), 80'(64'h6DAB31744F41D700));
            if (dif.done) begin
                got = 1'b1;
                lat = n;
            end else if (dif.busy) begin
                busy_cnt++;
            end
            scramble();
        end
        if (!got) begin
            timeout("run_done");
        end else begin
            check("latency",        80'(lat),           80'(63));
            check("busy_cycles",    80'(busy_cnt),      80'(63));
            check("busy_at_done",   80'(dif.busy),      80'(0));
            check("plaintext",      80'(dif.plaintext), 80'(v.pt));
            check("k_unwound_k1",   dut.k,              v.key);
            @(posedge Clock); #1;
            check("done_is_pulse",  80'(dif.done),      80'(0));
            check("plaintext_held", 80'(dif.plaintext), 80'(v.pt));
        end
    endtask

    initial begin
        int  lat;
        bit  got;
        bit  changed;
        int  done_seen;

        vecs[0] = '{ct: 64'h5579C1387B228445, key: 80'h0,                    pt: 64'h0000000000000000};
        vecs[1] = '{ct: 64'hE72C46C0F5945049, key: 80'hFFFFFFFFFFFFFFFFFFFF, pt: 64'h0000000000000000};
        vecs[2] = '{ct: 64'hA112FFC72F68417B, key: 80'h0,                    pt: 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{ct: 64'h3333DCD3213210D2, key: 80'hFFFFFFFFFFFFFFFFFFFF, pt: 64'hFFFFFFFFFFFFFFFF};

        Reset_n        = 1'b0;
        dif.start      = 1'b0;
        dif.ciphertext = '0;
        dif.key        = '0;
        @(posedge Clock); #1;
        check("rst_busy",      80'(dif.busy),      80'(0));
        check("rst_done",      80'(dif.done),      80'(0));
        check("rst_plaintext", 80'(dif.plaintext), 80'(0));
        check("rst_k",         dut.k,              80'(0));
        check("rst_rc",        80'(dut.rc),        80'(0));
        check("rst_state",     80'(dut.state),     80'(0));
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 4; i++)
            run_op(vecs[i], i == 0);

        // start held high throughout; inputs change every cycle after acceptance.
        dif.start      = 1'b1;
        dif.ciphertext = vecs[0].ct;
        dif.key        = vecs[0].key;
        @(posedge Clock); #1;
        scramble();
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(posedge Clock); #1;
            if (dif.done) begin got = 1'b1; lat = n; end
            scramble();
        end
        if (!got) timeout("held_first_done");
        else begin
            check("held_first_latency", 80'(lat),           80'(63));
            check("held_first_pt",      80'(dif.plaintext), 80'(vecs[0].pt));
        end
        dif.ciphertext = vecs[2].ct;
        dif.key        = vecs[2].key;
        @(posedge Clock); #1;
        check("held_accept_e64_busy", 80'(dif.busy), 80'(1));
        check("held_accept_e64_done", 80'(dif.done), 80'(0));
        scramble();
        got     = 1'b0;
        lat     = 0;
        changed = 1'b0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(posedge Clock); #1;
            if (dif.done) begin got = 1'b1; lat = n; end
            else if (dif.plaintext !== vecs[0].pt) changed = 1'b1;
            scramble();
        end
        dif.start = 1'b0;
        check("held_pt_stable", 80'(changed), 80'(0));
        if (!got) timeout("held_second_done");
        else begin
            check("held_second_latency", 80'(lat),           80'(63));
            check("held_second_pt",      80'(dif.plaintext), 80'(vecs[2].pt));
        end
        repeat (2) @(posedge Clock);
        #1;

        // Reset asserted mid-round, after E40.
        dif.start      = 1'b1;
        dif.ciphertext = vecs[3].ct;
        dif.key        = vecs[3].key;
        @(posedge Clock); #1;
        dif.start = 1'b0;
        repeat (40) @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midrst_busy",      80'(dif.busy),      80'(0));
        check("midrst_done",      80'(dif.done),      80'(0));
        check("midrst_plaintext", 80'(dif.plaintext), 80'(0));
        check("midrst_k",         dut.k,              80'(0));
        @(posedge Clock); @(posedge Clock); #1;
        Reset_n   = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge Clock); #1;
            if (dif.done || dif.busy) done_seen++;
        end
        check("midrst_no_activity", 80'(done_seen), 80'(0));
        run_op(vecs[3], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/present_dec_ctrl.md
# present_dec_ctrl

Iterative PRESENT-80 decryption engine and round scheduler. It accepts a 64-bit ciphertext and an 80-bit user key through a start/busy/done handshake. It runs the key schedule forward to the last round key, then runs 31 inverse rounds while unwinding the key schedule. Each inverse round is inverse P-layer, then inverse S-box, then round-key XOR. It sits between the crypto host interface and the shared `size`-wide (64-bit) inverse permutation datapath.

## Interface
- ROUNDS, 31: number of PRESENT rounds. Only 31 is standard-compliant; other values are for debug only.
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- ciphertext  in  64  block to decrypt; latched on the accepting edge
- key  in  80  user key K1; latched on the accepting edge
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; plaintext valid
- plaintext  out  64  result; held until the next done

## Operation
- Registers:
  - state[63:0]
  - k[79:0]
  - rc[4:0], the round counter
  - fsm in {IDLE, KEYFWD, WHITEN, ROUND}
- IDLE, start=1: latch state<=ciphertext, k<=key, rc<=1, busy<=1; go to KEYFWD.
- KEYFWD, one forward key update per cycle:
  - k <= rotl61(k);
  - then k[79:76] <= S(k[79:76]);
  - then k[19:15] ^= rc;
  - rc++.
  - After the update with rc=ROUNDS, k holds K32. Set rc<=ROUNDS and go to WHITEN.
- WHITEN: state <= state ^ k[79:16]; go to ROUND.
- ROUND, one round per cycle, all combinational within the cycle:
  - Inverse key step to K_rc:
    - t = k with t[19:15] ^= rc;
    - t[79:76] = Sinv(t[79:76]);
    - k <= rotr61(t).
  - Inverse P-layer: p[i] = state[(16*i) mod 63] for i=0..62; p[63] = state[63].
  - Inverse S-box on all 16 nibbles: s = Sinv(p).
  - state <= s ^ k_next[79:16].
  - rc--.
  - When rc==1 is processed: plaintext <= result, done<=1, busy<=0, go to IDLE.
- S-box tables (index 0..F):
  - S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  - Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A
- start is ignored while busy. ciphertext and key may change freely after the accepting edge.
- done is a pulse: it clears on the next edge unless a new completion occurs.

## Timing
- Reset values: busy=0, done=0, plaintext=0, fsm=IDLE, state=0, k=0, rc=0.
- Accepting edge is E0.
  - E1..E31: forward key updates.
  - E32: whitening.
  - E33..E63: rounds 31..1.
  - At E63, plaintext and done update and busy falls.
- Latency from E0 to done is 63 cycles. busy is high from E0 through E63, i.e. 63 cycles.
- Back-to-back: start sampled at E63 is ignored because fsm≠IDLE before that edge. start at E64 is accepted, giving a 64-cycle minimum initiation interval.
- Reset_n low at any time, including mid-KEYFWD or mid-ROUND:
  - all registers return to reset values immediately, with no done pulse;
  - the first start after release begins a clean operation.
- Reset_n deassertion is treated as synchronous to Clock by the system.

## Test plan
- key=0, ciphertext=5579C1387B228445, start for 1 cycle -> done at E63 with plaintext=0000000000000000; busy high exactly 63 cycles.
- key=FFFFFFFFFFFFFFFFFFFF, ciphertext=E72C46C0F5945049 -> plaintext=0000000000000000.
- key=0, ciphertext=A112FFC72F68417B -> plaintext=FFFFFFFFFFFFFFFF; then with key=all-F, ciphertext=3333DCD3213210D2 -> plaintext=FFFFFFFFFFFFFFFF.
- start held high continuously, with vectors changing every cycle while busy:
  - only the E0 values are used, and the result matches the E0 vector;
  - the next operation is accepted at E64;
  - plaintext is unchanged between done pulses.
- Reset_n pulsed low at E40 of an operation:
  - busy, done and plaintext read 0 asynchronously;
  - no done pulse follows;
  - a fresh start completes correctly 63 cycles later.
- Corner check of the inverse key unwind:
  - after a run, internal k equals the user key K1;
  - after WHITEN, k equals K32 = 6DAB31744F41D700 concatenated with the low 16 bits, for key=0.
